noc_mem_responder: RTL and testbench

NOC_MEM_RESPONDER -- requirements
Module: noc_mem_responder

---
 rtl/noc_mem_responder_if.sv | 31 +++
 rtl/noc_mem_responder.sv | 94 +++++++++
 tb/tb_noc_mem_responder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_mem_responder_if
// Brief    : NOC request/response bundle for the memory responder.
// Revision : 1.0
// ============================================================================
interface noc_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_src;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_dst;
    logic [7:0]  rsp_src;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_src, req_op, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_dst, rsp_src, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_src, req_op, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_dst, rsp_src, rsp_data, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/noc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : noc_mem_responder
// Brief    : Single-outstanding NOC memory target with range/alignment checks.
// Revision : 1.0
// ============================================================================
module noc_mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h0001_0000,
    parameter logic [7:0]  STOP_ID = 8'd1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    noc_mem_responder_if.slave bus
);
    localparam int unsigned c_IDX_W  = $clog2(DEPTH);
    localparam logic [32:0] c_SPAN   = 33'(DEPTH) << 2;
    localparam logic [1:0]  c_IDLE   = 2'd0;
    localparam logic [1:0]  c_ACCESS = 2'd1;
    localparam logic [1:0]  c_RESP   = 2'd2;

    logic [1:0]         r_state;
    logic [7:0]         r_src;
    logic [1:0]         r_op;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [7:0]         r_rsp_dst;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_err;
    logic [31:0]        r_mem [DEPTH];

    logic [32:0]        w_offset;
    logic               w_ok;
    logic               w_wr;
    logic [c_IDX_W-1:0] w_idx;

    // A borrow sets bit 32, so addresses below BASE land far above c_SPAN.
    assign w_offset = {1'b0, r_addr} - {1'b0, BASE};
    assign w_ok     = (w_offset < c_SPAN) && (r_addr[1:0] == 2'b00) && !r_op[1];
    assign w_idx    = w_offset[c_IDX_W+1:2];
    assign w_wr     = (r_state == c_ACCESS) && w_ok && r_op[0];

    // Storage is never cleared; reset only blocks a write on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_src      <= '0;
            r_op       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_dst  <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req_valid) begin
                        r_src   <= bus.req_src;
                        r_op    <= bus.req_op;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_data;
                        r_state <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    r_rsp_dst  <= r_src;
                    r_rsp_err  <= !w_ok;
                    r_rsp_data <= (w_ok && !r_op[0]) ? r_mem[w_idx] : 32'd0;
                    r_state    <= c_RESP;
                end
                c_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == c_IDLE);
    assign bus.rsp_valid = (r_state == c_RESP);
    assign bus.rsp_dst   = r_rsp_dst;
    assign bus.rsp_src   = STOP_ID;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
endmodule
`default_nettype wire

// File: tb/tb_noc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_mem_responder
// Brief    : Directed and random checks of noc_mem_responder against a model.
// Revision : 1.0
// ============================================================================
module tb_noc_mem_responder;
    localparam int          DEPTH   = 64;
    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam logic [7:0]  STOP_ID = 8'h5A;

    logic clk;
    logic rst;
    noc_mem_responder_if bus ();

    noc_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .STOP_ID(STOP_ID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  dst;
        logic [31:0] data;
        logic        err;
        bit          dchk;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_acc    = 0;
    int          n_xfer   = 0;
    bit          last_acc;
    bit          last_xfer;
    logic [7:0]  got_dst;
    logic [31:0] got_data;
    logic        got_err;

    logic [31:0] ref_mem [DEPTH];
    bit          ref_known [DEPTH];
    exp_t        exp_q [$];
    bit          pw_v = 1'b0;
    int          pw_idx;
    logic [31:0] pw_data;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] src, input logic [1:0] op,
                                input logic [31:0] addr, input logic [31:0] data);
        exp_t   e;
        longint a;
        int     idx;
        bit     ok;
        a   = longint'(addr);
        ok  = (a >= longint'(BASE)) && (a <= longint'(BASE) + DEPTH * 4 - 1) &&
              (addr % 4 == 0) && (op < 2);
        idx = ok ? int'((a - longint'(BASE)) / 4) : 0;
        e.dst  = src;
        e.data = 32'd0;
        e.err  = !ok;
        e.dchk = 1'b1;
        if (ok && op == 2'd1) begin
            pw_v    = 1'b1;
            pw_idx  = idx;
            pw_data = data;
        end else if (ok) begin
            e.data = ref_mem[idx];
            e.dchk = ref_known[idx];
        end
        exp_q.push_back(e);
    endtask

    // One clock: scoreboard bookkeeping on the values present before the edge.
    task automatic cycle();
        bit          acc;
        bit          xf;
        bit          hold;
        logic [49:0] snap;
        exp_t        e;
        acc  = !rst && bus.req_valid && bus.req_ready;
        xf   = !rst && bus.rsp_valid && bus.rsp_ready;
        hold = !rst && bus.rsp_valid && !bus.rsp_ready;
        snap = {bus.rsp_valid, bus.rsp_dst, bus.rsp_src, bus.rsp_data, bus.rsp_err};
        if (xf) begin
            got_dst  = bus.rsp_dst;
            got_data = bus.rsp_data;
            got_err  = bus.rsp_err;
            check_eq("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("rsp_dst", bus.rsp_dst, e.dst);
                check_eq("rsp_src", bus.rsp_src, STOP_ID);
                check_eq("rsp_err", bus.rsp_err, e.err);
                if (e.dchk) check_eq("rsp_data", bus.rsp_data, e.data);
            end
            n_xfer++;
        end
        if (pw_v) begin
            if (!rst) begin
                ref_mem[pw_idx]   = pw_data;
                ref_known[pw_idx] = 1'b1;
            end
            pw_v = 1'b0;
        end
        if (acc) begin
            model_accept(bus.req_src, bus.req_op, bus.req_addr, bus.req_data);
            n_acc++;
        end
        if (rst) exp_q.delete();
        @(posedge clk);
        #1;
        if (hold) check_eq("rsp_hold", {bus.rsp_valid, bus.rsp_dst, bus.rsp_src,
                                         bus.rsp_data, bus.rsp_err}, snap);
        last_acc  = acc;
        last_xfer = xf;
        cyc++;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [7:0] src);
        bit done;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_src   = src;
        bus.req_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = last_acc;
        end
        if (!done) check_eq("req_accept_timeout", 0, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic get_rsp();
        bit done;
        bus.rsp_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = last_xfer;
        end
        if (!done) check_eq("rsp_timeout", 0, 1);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr,
                            input logic exp_err, input logic [31:0] exp_data, input bit dchk);
        send(2'd0, addr, 32'd0, 8'h11);
        get_rsp();
        check_eq(tag, got_err, exp_err);
        if (dchk) check_eq(tag, got_data, exp_data);
    endtask

    initial begin
        int  t0;
        int  sent;
        int  guard;
        int  r;
        bit  seen;
        logic [31:0] addr;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_src   = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        check_eq("rst_req_ready", bus.req_ready, 1);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_dst", bus.rsp_dst, 0);
        check_eq("rst_rsp_data", bus.rsp_data, 0);
        check_eq("rst_rsp_err", bus.rsp_err, 0);
        check_eq("rst_rsp_src", bus.rsp_src, STOP_ID);

        for (int i = 0; i < DEPTH; i++) begin
            send(2'd1, BASE + 32'(4 * i), $urandom, 8'(i));
            get_rsp();
        end

        // Write then read, with rsp_ready already high for the write.
        bus.rsp_ready = 1'b1;
        send(2'd1, BASE + 32'd8, 32'hDEAD_BEEF, 8'h03);
        t0 = cyc;
        get_rsp();
        check_eq("wr_latency", cyc - t0, 2);
        check_eq("wr_dst", got_dst, 8'h03);
        check_eq("wr_err", got_err, 0);
        check_eq("wr_data", got_data, 0);
        bus.rsp_ready = 1'b0;
        send(2'd0, BASE + 32'd8, 32'd0, 8'h03);
        check_eq("rd_access_no_valid", bus.rsp_valid, 0);
        cycle();
        check_eq("rd_valid_2cyc", bus.rsp_valid, 1);
        check_eq("rd_data", bus.rsp_data, 32'hDEAD_BEEF);
        check_eq("rd_err", bus.rsp_err, 0);
        get_rsp();

        rd_check("bnd_last", BASE + 32'(DEPTH * 4 - 4), 1'b0, 32'd0, 1'b0);
        rd_check("bnd_over", BASE + 32'(DEPTH * 4), 1'b1, 32'd0, 1'b1);
        rd_check("bnd_below", BASE - 32'd4, 1'b1, 32'd0, 1'b1);
        rd_check("bnd_misalign", BASE + 32'd2, 1'b1, 32'd0, 1'b1);

        send(2'd1, BASE + 32'd12, 32'h0BAD_F00D, 8'h07);
        get_rsp();
        send(2'd2, BASE + 32'd12, 32'hFFFF_FFFF, 8'h07);
        get_rsp();
        check_eq("rsvd_err", got_err, 1);
        check_eq("rsvd_data", got_data, 0);
        rd_check("rsvd_unchanged", BASE + 32'd12, 1'b0, 32'h0BAD_F00D, 1'b1);

        // Back-pressure in RESP.
        bus.rsp_ready = 1'b0;
        send(2'd0, BASE + 32'd8, 32'd0, 8'h21);
        for (int i = 0; i < 10 && !bus.rsp_valid; i++) cycle();
        check_eq("bp_valid_rise", bus.rsp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("bp_valid_held", bus.rsp_valid, 1);
            check_eq("bp_req_ready_low", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        cycle();
        check_eq("bp_xfer", last_xfer, 1);
        check_eq("bp_data", got_data, 32'hDEAD_BEEF);
        check_eq("bp_req_ready_after", bus.req_ready, 1);
        check_eq("bp_valid_after", bus.rsp_valid, 0);
        cycle();
        check_eq("bp_single_xfer", last_xfer, 0);

        // Reset on the ACCESS edge of a write.
        send(2'd1, BASE + 32'd16, 32'hAAAA_AAAA, 8'h05);
        get_rsp();
        send(2'd1, BASE + 32'd16, 32'h1234_5678, 8'h05);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("midrst_req_ready", bus.req_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_xfer || bus.rsp_valid) seen = 1'b1;
        end
        check_eq("midrst_no_rsp", seen, 0);
        rd_check("midrst_unchanged", BASE + 32'd16, 1'b0, 32'hAAAA_AAAA, 1'b1);

        // Random stream with stalls on both sides.
        n_acc     = 0;
        n_xfer    = 0;
        sent      = 0;
        guard     = 0;
        last_acc  = 1'b0;
        while ((sent < 1000 || bus.req_valid) && guard < 20000) begin
            if (last_acc) bus.req_valid = 1'b0;
            if (!bus.req_valid && sent < 1000 && $urandom_range(0, 9) < 7) begin
                r = int'($urandom_range(0, 99));
                if (r < 80)      addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                else if (r < 88) addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                else if (r < 94) addr = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 3));
                else             addr = BASE - 32'(4 * $urandom_range(1, 4));
                bus.req_op    = ($urandom_range(0, 19) == 0) ? 2'(2 + $urandom_range(0, 1))
                                                             : 2'($urandom_range(0, 1));
                bus.req_addr  = addr;
                bus.req_data  = $urandom;
                bus.req_src   = 8'($urandom_range(0, 255));
                bus.req_valid = 1'b1;
                sent++;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            guard++;
        end
        check_eq("rand_budget", guard < 20000, 1);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.rsp_valid); i++) cycle();
        check_eq("rand_accepted", n_acc, 1000);
        check_eq("rand_counts_equal", n_xfer, n_acc);
        check_eq("rand_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
